// File: rtl/dense_pkg.sv
// Shared FSM state type and saturation helper for dense-layer blocks.
package dense_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        DONE
    } dense_state_e;

    localparam int SAT_W = 64;

    // Clamp a sign-extended value to the signed range of an ow-bit result.
    function automatic logic signed [SAT_W-1:0] sat_to_ow(
        input logic signed [SAT_W-1:0] v,
        input int unsigned             ow
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = $signed((64'd1 << (ow - 1)) - 64'd1);
        lo = ~hi;
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/dense_mac_lane.sv
// One output neuron: multiply-accumulate, arithmetic shift, saturate.
// Negative results clamp to zero when DENSE_RELU_EN is defined.
module dense_mac_lane
    import dense_pkg::*;
#(
    parameter int DW    = 8,
    parameter int WW    = 8,
    parameter int OW    = 8,
    parameter int ACC_W = 20,
    parameter int SHIFT = 0
) (
    input  logic          clk,
    input  logic          xrst,
    input  logic          clear,
    input  logic          acc_en,
    input  logic          load_y,
    input  logic [DW-1:0] x,
    input  logic [WW-1:0] w,
    output logic [OW-1:0] y
);

    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;
    logic [OW-1:0]           y_q;
    logic [OW-1:0]           y_d;
    logic [DW+WW-1:0]        prod;
    logic signed [ACC_W-1:0] shifted;
    logic signed [OW-1:0]    sat_res;

    // Operands are sign-extended to product width so the low bits form the exact signed product.
    always_comb begin
        prod    = {{WW{x[DW-1]}}, x} * {{DW{w[WW-1]}}, w};
        acc_d   = acc_q;
        if (clear) begin
            acc_d = '0;
        end else if (acc_en) begin
            acc_d = acc_q + $signed({{(ACC_W-DW-WW){prod[DW+WW-1]}}, prod});
        end
        shifted = acc_q >>> SHIFT;
        sat_res = OW'(sat_to_ow({{(SAT_W-ACC_W){shifted[ACC_W-1]}}, shifted}, OW));
        y_d     = y_q;
        if (load_y) begin
`ifdef DENSE_RELU_EN
            y_d = sat_res[OW-1] ? '0 : sat_res;
`else
            y_d = sat_res;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!xrst) begin
            acc_q <= '0;
            y_q   <= '0;
        end else begin
            acc_q <= acc_d;
            y_q   <= y_d;
        end
    end

    assign y = y_q;

endmodule

// File: rtl/dense_layer_engine.sv
// Dense layer: streams DEPTH activation/weight pairs into N_CH parallel MAC lanes.
// Optional ReLU on the outputs is enabled by defining DENSE_RELU_EN.
module dense_layer_engine
    import dense_pkg::*;
#(
    parameter int N_CH  = 16,
    parameter int DEPTH = 16,
    parameter int DW    = 8,
    parameter int WW    = 8,
    parameter int OW    = 8,
    parameter int SHIFT = 0
) (
    input  logic                          clk,
    input  logic                          xrst,
    input  logic                          start,
    output logic                          busy,
    output logic                          finish,
    output logic [$clog2(DEPTH)-1:0]      x_raddr,
    input  logic [DW-1:0]                 x_rdata,
    output logic [N_CH*$clog2(DEPTH)-1:0] w_raddr,
    input  logic [N_CH*WW-1:0]            w_rdata,
    output logic [N_CH*OW-1:0]            y_data
);

    localparam int AW    = $clog2(DEPTH);
    localparam int ACC_W = DW + WW + AW;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    dense_state_e  state_q;
    dense_state_e  state_d;
    logic [AW-1:0] cnt_q;
    logic [AW-1:0] cnt_d;
    logic          valid_q;
    logic          valid_d;
    logic          finish_q;
    logic          finish_d;
    logic          clear;
    logic          load_y;
    logic [AW-1:0] addr;

    // valid tracks the one-cycle memory latency: data for an address arrives a cycle later.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        valid_d  = (state_q == FETCH);
        finish_d = 1'b0;
        clear    = 1'b0;
        load_y   = 1'b0;
        addr     = (state_q == FETCH) ? cnt_q : '0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                    cnt_d   = '0;
                    clear   = 1'b1;
                end
            end
            FETCH: begin
                if (cnt_q == LAST) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            DRAIN: begin
                state_d = DONE;
            end
            DONE: begin
                load_y   = 1'b1;
                finish_d = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!xrst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            finish_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            finish_q <= finish_d;
        end
    end

    assign x_raddr = addr;
    assign w_raddr = {N_CH{addr}};
    assign finish  = finish_q;
    assign busy    = (state_q != IDLE) || finish_q;

    for (genvar k = 0; k < N_CH; k++) begin : g_lane
        dense_mac_lane #(
            .DW   (DW),
            .WW   (WW),
            .OW   (OW),
            .ACC_W(ACC_W),
            .SHIFT(SHIFT)
        ) u_lane (
            .clk   (clk),
            .xrst  (xrst),
            .clear (clear),
            .acc_en(valid_q),
            .load_y(load_y),
            .x     (x_rdata),
            .w     (w_rdata[k*WW +: WW]),
            .y     (y_data[k*OW +: OW])
        );
    end

endmodule

// File: doc/dense_layer_engine.md
DENSE_LAYER_ENGINE -- requirements
Module: dense_layer_engine

Interface
REQ-001 Parameter N_CH, default 16, number of output neurons (parallel weight channels), 1..64.
REQ-002 Parameter DEPTH, default 16, inputs per neuron, 2..1024.
REQ-003 Parameter DW, default 8, signed activation width.
REQ-004 Parameter WW, default 8, signed weight width.
REQ-005 Parameter OW, default 8, signed output width.
REQ-006 Parameter SHIFT, default 0, arithmetic right shift applied before saturation, 0..(DW+WW-1).
REQ-007 Derived: AW = clog2(DEPTH); ACC_W = DW+WW+AW.
REQ-008 clk  in  1  single clock; all logic on rising edge.
REQ-009 xrst  in  1  reset, synchronous, active-low.
REQ-010 start  in  1  one-cycle request to compute one layer pass.
REQ-011 busy  out  1  high from the cycle after start acceptance until finish inclusive.
REQ-012 finish  out  1  one-cycle pulse; y_data valid from this cycle onward.
REQ-013 x_raddr  out  AW  activation memory read address.
REQ-014 x_rdata  in  DW  signed activation, valid one cycle after x_raddr.
REQ-015 w_raddr  out  N_CH*AW  per-channel weight read addresses, channel k at bits [k*AW +: AW].
REQ-016 w_rdata  in  N_CH*WW  per-channel signed weights, one-cycle read latency.
REQ-017 y_data  out  N_CH*OW  per-channel signed results, channel k at [k*OW +: OW].

Function
REQ-018 FSM states IDLE, FETCH, DRAIN, DONE; IDLE->FETCH on start, FETCH->DRAIN after address DEPTH-1 issued, DRAIN->DONE after one cycle, DONE->IDLE unconditionally.
REQ-019 Start sampled in IDLE only; start in any other state is ignored.
REQ-020 Start acceptance clears all accumulators to 0.
REQ-021 In FETCH, x_raddr and every w_raddr channel carry the same index, 0..DEPTH-1, one increment per cycle.
REQ-022 Each cycle after an address is issued, every channel adds x_rdata*w_rdata[k] (full-precision signed product) into its ACC_W accumulator; no overflow is possible at ACC_W.
REQ-023 In DONE, each channel computes acc >>> SHIFT, saturates to [-2^(OW-1), 2^(OW-1)-1], registers into y_data, and finish pulses.
REQ-024 Latency: finish high exactly DEPTH+2 cycles after the start-sampling edge.
REQ-025 y_data holds its value until the next finish; it is not disturbed during a pass.
REQ-026 Addresses read 0 when not in FETCH.
REQ-027 Start asserted in the cycle after finish (IDLE) is accepted: back-to-back passes, no dead cycles beyond DONE.

Reset
REQ-028 xrst low at an edge: state IDLE, busy 0, finish 0, all addresses 0, accumulators 0, y_data 0; takes precedence over start.
REQ-029 Reset mid-pass aborts the pass; no finish is produced for it.

Configuration
REQ-030 Macro DENSE_RELU_EN defined: after saturation, negative channel results are replaced by 0.
REQ-031 Macro DENSE_RELU_EN undefined: saturated signed result is output unchanged; no ReLU logic is present.

Structure
REQ-032 Package dense_pkg holds the FSM state enum and a saturate-to-OW function shared with future layer blocks.
REQ-033 Sub-module dense_mac_lane (one accumulator, multiply-add, shift, saturate, optional ReLU) is instantiated N_CH times via generate.

Verification
REQ-034 Defaults, all x=1, all w=1, start -> finish at cycle 18, every channel y=16.
REQ-035 x=127, w=127, SHIFT=0 -> sum 258064 saturates, y=127 all channels.
REQ-036 x=-128, w=127 -> y=-128 without DENSE_RELU_EN, y=0 with it.
REQ-037 Channel k weights = k-8, x=1, SHIFT=2 -> y[k]=floor(16*(k-8)/4)=4*(k-8), saturated to 8-bit range.
REQ-038 Start pulsed again at cycle 5 of a pass -> ignored, single finish at cycle 18; start at cycle 19 -> second finish at cycle 37.
REQ-039 xrst low at cycle 10 of a pass -> busy 0, y_data 0, no finish; fresh start afterwards completes normally.
